// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver that presents each byte with a one-cycle
// data_valid strobe. The line is oversampled at the system clock, and each
// bit is sampled at its midpoint.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing and adds the
// parity_err output.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int CW      = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] MID  = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic [7:0]    data_q;
    logic          data_valid_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          rxd_meta_q;
    logic          rxd_s_q;
    logic          rxd_prev_q;
    logic          fall_d;
    logic          mid_d;
    logic          wrap_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q;
    logic          parity_err_q;
`endif

    // Two-flop synchroniser plus a delayed copy for edge detection.
    // All three flops reset to 1 so that reset does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    // Decode the start-edge, mid-bit and end-of-bit events.
    always_comb begin
        fall_d = rxd_prev_q & ~rxd_s_q;
        mid_d  = (baud_cnt_q == MID);
        wrap_d = (baud_cnt_q == LAST);
    end

    // Receive FSM. The strobes default low each cycle, so each one is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            baud_cnt_q   <= wrap_d ? '0 : baud_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    if (fall_d) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    // A start bit that is high at mid-bit was only a glitch.
                    if (mid_d && rxd_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (wrap_d) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (mid_d)
                        shreg_q <= {rxd_s_q, shreg_q[7:1]};
                    if (wrap_d) begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_d)
                        par_bit_q <= rxd_s_q;
                    if (wrap_d)
                        state_q <= STOP;
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (mid_d) begin
                        if (rxd_s_q) begin
                            data_q       <= shreg_q;
                            data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= ^{shreg_q, par_bit_q};
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and random UART frames checked against a
// frame-level reference model of expected bytes and pulse counts.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BIT_DIV  = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS_AFTER_START = 10;
`else
    localparam int NBITS_AFTER_START = 9;
`endif
    // Expected delay from driving the start edge to the data_valid pulse:
    // 2 sync cycles plus (bits before stop + half of the stop bit) * BIT_DIV.
    localparam int LAT_NOM = 2 + ((2 * NBITS_AFTER_START + 1) * BIT_DIV) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pe_cnt  = 0;
    int         exp_pe  = 0;
`endif
    logic       par_flip = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int t_dv   = 0;
    int t_start = 0;
    logic pulse_prev = 1'b0;

    // Reference model state: byte-level expectations only.
    logic [7:0] exp_data = 8'h00;
    int exp_dv = 0;
    int exp_fe = 0;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts strobes and checks they are exclusive and single-cycle.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt++;
            t_dv = cyc;
        end
        if (frame_err === 1'b1) fe_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) begin
            pe_cnt++;
            chk("pe_with_dv", {31'b0, data_valid}, 32'd1);
        end
`endif
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            chk("dv_fe_excl", {31'b0, data_valid & frame_err}, 32'd0);
            chk("pulse_1cyc", {31'b0, pulse_prev}, 32'd0);
        end
        pulse_prev = data_valid | frame_err;
    end

    // Drives one frame starting at the current negedge and ends on a negedge,
    // so consecutive calls produce back-to-back frames. It also updates the model.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        t_start = cyc;
        repeat (BIT_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (BIT_DIV) @(negedge clk);
        if (stop && par_flip) exp_pe++;
`endif
        rxd = stop;
        repeat (BIT_DIV) @(negedge clk);
        rxd = 1'b1;
        if (stop) begin
            exp_dv++;
            exp_data = b;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic check_rx(input string tag, input logic good);
        chk({tag, "_dv_cnt"}, dv_cnt, exp_dv);
        chk({tag, "_fe_cnt"}, fe_cnt, exp_fe);
        chk({tag, "_data"}, {24'b0, data}, {24'b0, exp_data});
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk({tag, "_pe_cnt"}, pe_cnt, exp_pe);
`endif
        if (good) begin
            int lat;
            lat = t_dv - t_start;
            chk({tag, "_latency_ok"}, {31'b0, (lat >= LAT_NOM - 2) && (lat <= LAT_NOM + 2)}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] hello [5];
        logic [7:0] rb;
        logic       rs;
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

        // 1: reset held with rxd toggling.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rxd = $urandom_range(1);
            chk("rst_data", {24'b0, data}, 32'h0);
            chk("rst_dv", {31'b0, data_valid}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
        end
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // 2: single 'H'.
        send_frame(8'h48, 1'b1);
        check_rx("H", 1'b1);

        // 3: "Hello" back-to-back.
        foreach (hello[i]) begin
            send_frame(hello[i], 1'b1);
            check_rx("hello", 1'b1);
        end
        repeat (BIT_DIV) @(negedge clk);

        // 4: short low glitch is rejected.
        rxd = 1'b0;
        repeat (60) @(negedge clk);
        chk("glitch_busy_hi", {31'b0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_DIV) @(negedge clk);
        check_rx("glitch", 1'b0);

        // 5: bad stop bit leaves data unchanged.
        send_frame(8'h55, 1'b0);
        repeat (BIT_DIV) @(negedge clk);
        check_rx("ferr", 1'b0);

        // 6: reset during data bit 4, then a clean frame.
        rb = 8'hA5;
        rxd = 1'b0;
        repeat (BIT_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = rb[i];
            repeat (BIT_DIV) @(negedge clk);
        end
        rxd = rb[4];
        repeat (BIT_DIV / 2) @(negedge clk);
        chk("midframe_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_data", {24'b0, data}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        rxd = 1'b1;
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (2 * BIT_DIV) @(negedge clk);
        check_rx("midrst", 1'b0);
        send_frame(8'h6F, 1'b1);
        check_rx("after_rst", 1'b1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: byte is delivered but flagged.
        par_flip = 1'b1;
        send_frame(8'h6C, 1'b1);
        par_flip = 1'b0;
        check_rx("parity", 1'b1);
`endif

        // Random frames with occasional bad stop bits and random idle gaps.
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(3) != 0);
            send_frame(rb, rs);
            if (!rs) repeat (BIT_DIV) @(negedge clk);
            check_rx("rand", rs);
            repeat ($urandom_range(40)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
